// File: rtl/fpdiv_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-precision divider among NREQ requesters.
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT (DIV_LAT cycles) -> RESP -> IDLE.
module fpdiv_arbiter #(
   parameter int  NREQ    = 4,
   parameter int  DIV_LAT = 16,   // legal range 2..255; must fit the 8-bit wait counter
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [31:0]          resp_z,
   output logic                 div_start,
   output logic [31:0]          div_a,
   output logic [31:0]          div_b,
   input  logic [31:0]          div_z,
   output logic                 busy,
   output logic [IDW-1:0]       grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] last_q, last_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [31:0]    a_q, a_d;
   logic [31:0]    b_q, b_d;
   logic [31:0]    z_q, z_d;

   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] cand;
   logic [31:0]    sel_a, sel_b;

   // Round-robin search starting just above the last completed grant.
   // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_q) + k) % NREQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == IDW'(i)) begin
            sel_a = req_a[32*i +: 32];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      z_d        = z_q;
      req_ready  = '0;
      resp_valid = '0;
      div_start  = 1'b0;

      case (state_q)
         IDLE: begin
            // Gated by reset so nothing is accepted before the first edge with reset released.
            if (reset && pick_found) begin
               req_ready[pick_idx] = 1'b1;
               grant_d             = pick_idx;
               a_d                 = sel_a;
               b_d                 = sel_b;
               state_d             = ISSUE;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(DIV_LAT - 1)) begin
               z_d     = div_z;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   // NOTE: operand and result registers are reset too, because their values are visible on outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         z_q     <= z_d;
      end
   end

   assign div_a    = a_q;
   assign div_b    = b_q;
   assign resp_z   = z_q;
   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Self-checking bench for fpdiv_arbiter: fixed-latency divider model plus an accept/response scoreboard.
module tb_fpdiv_arbiter;

   localparam int NREQ    = 4;
   localparam int DIV_LAT = 16;
   localparam int IDW     = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [32*NREQ-1:0]   req_a, req_b;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      resp_valid;
   logic [NREQ-1:0]      resp_ready;
   logic [31:0]          resp_z;
   logic                 div_start;
   logic [31:0]          div_a, div_b;
   logic [31:0]          div_z;
   logic                 busy;
   logic [IDW-1:0]       grant_id;

   fpdiv_arbiter #(.NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
      .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_z(div_z),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in divider: result valid only in the DIV_LAT-th cycle after div_start, garbage otherwise.
   function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
   endfunction

   logic        dm_act = 1'b0;
   logic [7:0]  dm_cnt = 8'd0;
   logic [31:0] dm_a = '0, dm_b = '0;
   always @(posedge clk) begin
      if (div_start) begin
         dm_act <= 1'b1;
         dm_cnt <= 8'd1;
         dm_a   <= div_a;
         dm_b   <= div_b;
      end else if (dm_act) begin
         dm_cnt <= dm_cnt + 8'd1;
         if (dm_cnt == 8'(DIV_LAT)) dm_act <= 1'b0;
      end
   end
   assign div_z = (dm_act && dm_cnt == 8'(DIV_LAT)) ? div_model(dm_a, dm_b) : 32'hDEAD_BEEF;

   typedef struct { int id; logic [31:0] z; } exp_t;
   exp_t          sb_q[$];
   int            order_q[$];
   logic [NREQ-1:0] rr_seen, rv_seen;
   int            n_checks = 0;
   int            n_pass   = 0;

   // Scoreboard: push on every accept, pop and compare on every response handshake.
   task automatic mon();
      exp_t e;
      if (!reset) begin
         sb_q.delete();
         return;
      end
      rr_seen |= req_ready;
      rv_seen |= resp_valid;
      if (req_ready != '0) begin
         n_checks++;
         if ((req_ready & ~req_valid) != '0 || !$onehot(req_ready))
            $display("FAIL accept_strobe: req_ready=%b req_valid=%b", req_ready, req_valid);
         else n_pass++;
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
               sb_q.push_back('{i, div_model(req_a[32*i +: 32], req_b[32*i +: 32])});
               order_q.push_back(i);
            end
         end
      end
      if ((resp_valid & resp_ready) != '0) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            $display("FAIL unexpected_resp: resp_valid=%b with empty scoreboard", resp_valid);
         end else begin
            n_pass++;
            e = sb_q.pop_front();
            n_checks++;
            if (resp_valid !== NREQ'(1 << e.id))
               $display("FAIL resp_target: got %b expected %b", resp_valid, NREQ'(1 << e.id));
            else n_pass++;
            n_checks++;
            if (resp_z !== e.z)
               $display("FAIL resp_z: got %h expected %h (req %0d)", resp_z, e.z, e.id);
            else n_pass++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
   endtask

   task automatic wait_accept(input int budget, output bit found);
      found = 1'b0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (req_ready != '0) begin
            found = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic wait_resp(input int budget, output bit found);
      found = 1'b0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (resp_valid != '0) begin
            found = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic wait_idle(input int budget, output bit found);
      found = 1'b0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (!busy) begin
            found = 1'b1;
            return;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      req_valid  = '1;
      resp_ready = '0;
      repeat (3) step();
      tick();
      n_checks++; if (req_ready !== '0)  $display("FAIL rst_req_ready: got %b expected 0", req_ready);   else n_pass++;
      n_checks++; if (resp_valid !== '0) $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); else n_pass++;
      n_checks++; if (div_start !== 1'b0) $display("FAIL rst_div_start: got %b expected 0", div_start);  else n_pass++;
      n_checks++; if (busy !== 1'b0)     $display("FAIL rst_busy: got %b expected 0", busy);             else n_pass++;
      n_checks++; if ({div_a, div_b, resp_z} !== '0)
                     $display("FAIL rst_data: got %h %h %h expected 0", div_a, div_b, resp_z);           else n_pass++;
      n_checks++; if (grant_id !== '0)   $display("FAIL rst_grant_id: got %0d expected 0", grant_id);    else n_pass++;
      step();
      reset     = 1'b1;
      req_valid = '0;
      step();
   endtask

   task automatic test_latency();
      int lat = -1;
      int extra_start = 0;
      req_valid = 4'b0001;
      tick();
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL lat_accept: got %b expected 0001", req_ready); else n_pass++;
      step();
      req_valid = '0;
      tick();
      n_checks++; if (div_start !== 1'b1) $display("FAIL lat_div_start: got %b expected 1 at T+1", div_start); else n_pass++;
      n_checks++; if (div_a !== 32'h40C0_0000 || div_b !== 32'h4000_0000)
                     $display("FAIL lat_operands: got %h/%h expected 40c00000/40000000", div_a, div_b); else n_pass++;
      for (int n = 2; n < 60; n++) begin
         step();
         tick();
         if (div_start) extra_start++;
         if (resp_valid != '0) begin
            lat = n;
            break;
         end
      end
      n_checks++; if (lat != DIV_LAT + 2) $display("FAIL lat_resp_cycle: got T+%0d expected T+%0d", lat, DIV_LAT + 2); else n_pass++;
      n_checks++; if (extra_start != 0) $display("FAIL lat_single_start: got %0d extra pulses expected 0", extra_start); else n_pass++;
      n_checks++; if (resp_valid !== 4'b0001) $display("FAIL lat_resp_valid: got %b expected 0001", resp_valid); else n_pass++;
      n_checks++; if (resp_z !== 32'h4040_0000) $display("FAIL lat_resp_z: got %h expected 40400000", resp_z); else n_pass++;
      step();
      resp_ready = 4'b0001;
      tick();
      step();
      resp_ready = '0;
      tick();
      n_checks++; if (busy !== 1'b0 || resp_valid !== '0)
                     $display("FAIL lat_complete: busy=%b resp_valid=%b expected 0/0", busy, resp_valid); else n_pass++;
   endtask

   task automatic test_round_robin();
      int n_acc = 0;
      int lows = 0;
      int last_acc = 0;
      bit found;
      logic [19:0] enc = '0;
      step();
      reset = 1'b0;
      step();
      step();
      reset      = 1'b1;
      order_q.delete();
      req_valid  = '1;
      resp_ready = '1;
      for (int n = 0; n < 200 && n_acc < 5; n++) begin
         tick();
         if (!busy) lows++;
         if (req_ready != '0) begin
            if (n_acc > 0) begin
               n_checks++;
               if (cyc - last_acc != DIV_LAT + 3)
                  $display("FAIL rr_gap: got %0d cycles expected %0d", cyc - last_acc, DIV_LAT + 3);
               else n_pass++;
            end
            last_acc = cyc;
            n_acc++;
         end
         if (n_acc < 5) step();
      end
      n_checks++; if (n_acc != 5) $display("FAIL rr_accepts: got %0d expected 5", n_acc); else n_pass++;
      n_checks++; if (lows != 5) $display("FAIL rr_idle_cycles: got %0d expected 5", lows); else n_pass++;
      foreach (order_q[i]) enc = {enc[15:0], 4'(order_q[i])};
      n_checks++; if (enc !== 20'h01230) $display("FAIL rr_order: got %h expected 01230", enc); else n_pass++;
      step();
      req_valid = '0;
      wait_idle(60, found);
      n_checks++; if (!found) $display("FAIL rr_drain: got busy expected idle within 60 cycles"); else n_pass++;
   endtask

   task automatic test_resp_stall();
      bit found;
      int bad = 0;
      logic [31:0] hold_z;
      step();
      req_valid  = 4'b0100;
      resp_ready = '0;
      wait_accept(10, found);
      n_checks++; if (!found || req_ready !== 4'b0100) $display("FAIL stall_accept: got %b expected 0100", req_ready); else n_pass++;
      step();
      req_valid = 4'b0110;
      rr_seen   = '0;
      wait_resp(40, found);
      n_checks++; if (!found || resp_valid !== 4'b0100) $display("FAIL stall_resp: got %b expected 0100", resp_valid); else n_pass++;
      hold_z = resp_z;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin
            step();
            tick();
         end
         if (resp_valid !== 4'b0100 || resp_z !== hold_z) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad); else n_pass++;
      n_checks++; if (hold_z !== div_model(req_a[64 +: 32], req_b[64 +: 32]))
                     $display("FAIL stall_z: got %h expected %h", hold_z, div_model(req_a[64 +: 32], req_b[64 +: 32])); else n_pass++;
      n_checks++; if (rr_seen !== '0) $display("FAIL stall_no_accept: got req_ready history %b expected 0000", rr_seen); else n_pass++;
      step();
      resp_ready = 4'b0100;
      tick();
      step();
      resp_ready = '0;
      tick();
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL stall_next_grant: got %b expected 0010", req_ready); else n_pass++;
   endtask

   task automatic test_wait_pulse_foreign_ready();
      bit found;
      int bad = 0;
      step();
      req_valid = '0;
      rr_seen   = '0;
      rv_seen   = '0;
      step();
      tick();
      step();
      tick();
      step();
      req_valid = 4'b1000;
      tick();
      step();
      req_valid = '0;
      wait_resp(40, found);
      n_checks++; if (!found || resp_valid !== 4'b0010) $display("FAIL foreign_resp: got %b expected 0010", resp_valid); else n_pass++;
      step();
      resp_ready = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (resp_valid !== 4'b0010 || !busy) bad++;
         step();
      end
      n_checks++; if (bad != 0) $display("FAIL foreign_ready_ignored: got %0d early exits expected 0", bad); else n_pass++;
      resp_ready = 4'b0010;
      tick();
      step();
      resp_ready = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         step();
      end
      tick();
      n_checks++; if (rr_seen[3] !== 1'b0) $display("FAIL pulse_no_accept: got req_ready[3]=1 expected 0"); else n_pass++;
      n_checks++; if (rv_seen[3] !== 1'b0) $display("FAIL pulse_no_resp: got resp_valid[3]=1 expected 0"); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL pulse_idle: got busy=%b expected 0", busy); else n_pass++;
   endtask

   task automatic test_reset_abort();
      bit found;
      logic [7:0] enc = '0;
      step();
      req_valid = 4'b0001;
      tick();
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL abort_accept: got %b expected 0001", req_ready); else n_pass++;
      step();
      req_valid = '0;
      repeat (5) step();
      reset     = 1'b0;
      req_valid = 4'b1010;
      order_q.delete();
      tick();
      step();
      tick();
      n_checks++; if ({req_ready, resp_valid, div_start, busy} !== '0)
                     $display("FAIL abort_ctrl: got rr=%b rv=%b ds=%b busy=%b expected all 0", req_ready, resp_valid, div_start, busy); else n_pass++;
      n_checks++; if ({div_a, div_b, resp_z} !== '0 || grant_id !== '0)
                     $display("FAIL abort_data: got %h %h %h gid=%0d expected 0", div_a, div_b, resp_z, grant_id); else n_pass++;
      step();
      reset = 1'b1;
      tick();
      n_checks++; if (req_ready !== 4'b0010) $display("FAIL abort_next_grant: got %b expected 0010", req_ready); else n_pass++;
      step();
      req_valid  = 4'b1000;
      resp_ready = '1;
      wait_accept(60, found);
      n_checks++; if (!found || req_ready !== 4'b1000) $display("FAIL abort_second_grant: got %b expected 1000", req_ready); else n_pass++;
      step();
      req_valid = '0;
      wait_idle(60, found);
      n_checks++; if (!found) $display("FAIL abort_drain: got busy expected idle within 60 cycles"); else n_pass++;
      foreach (order_q[i]) enc = {enc[3:0], 4'(order_q[i])};
      n_checks++; if (enc !== 8'h13) $display("FAIL abort_order: got %h expected 13", enc); else n_pass++;
      n_checks++; if (sb_q.size() != 0) $display("FAIL abort_scoreboard: got %0d pending expected 0", sb_q.size()); else n_pass++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 time units");
      $fatal(1);
   end

   initial begin
      rr_seen = '0;
      rv_seen = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = 32'h3F80_0000 + 32'(i) * 32'h0012_3400;
         req_b[32*i +: 32] = 32'h4000_0000 + 32'(i) * 32'h0003_0100;
      end
      req_a[31:0] = 32'h40C0_0000;
      req_b[31:0] = 32'h4000_0000;
      test_reset();
      test_latency();
      test_round_robin();
      test_resp_stall();
      test_wait_pulse_foreign_ready();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpdiv_arbiter.md
FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one single-precision divider.
REQ-002 Parameter DIV_LAT, default 16: fixed cycles from div_start pulse to valid div_z; legal range 2..255.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  32*NREQ  dividend, IEEE-754 single; requester i in bits [32i+31:32i].
REQ-007 req_b  input  32*NREQ  divisor, same packing.
REQ-008 req_ready  output  NREQ  one-hot accept strobe.
REQ-009 resp_valid  output  NREQ  one-hot result-valid to the granted requester.
REQ-010 resp_ready  input  NREQ  per-requester result acceptance.
REQ-011 resp_z  output  32  quotient, shared by all requesters.
REQ-012 div_start  output  1  one-cycle start pulse to the divider.
REQ-013 div_a, div_b  output  32 each  divider operands.
REQ-014 div_z  input  32  divider result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  clog2(NREQ)  index of current or last granted requester.

Function
REQ-017 The block SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req_valid bit is set, the block SHALL select one requester by round-robin, pulse its req_ready for exactly one cycle, latch its req_a/req_b and index, and go to ISSUE; otherwise remain in IDLE.
REQ-019 Round-robin: search SHALL start at (last_grant+1) mod NREQ and proceed upward with wrap; last_grant SHALL update only on response completion.
REQ-020 req_ready SHALL assert only in IDLE, only when the corresponding req_valid is high, at most one bit per cycle.
REQ-021 ISSUE: div_start SHALL be 1 for exactly this one cycle; next state is WAIT with the cycle counter cleared.
REQ-022 div_a/div_b SHALL present the latched operands from ISSUE through the end of WAIT and stay stable; they SHALL keep their values in other states.
REQ-023 WAIT: the 8-bit counter SHALL increment each cycle; in the DIV_LAT-th WAIT cycle the block SHALL capture div_z into the result register and go to RESP.
REQ-024 Latency: accept in cycle T gives div_start in T+1 and resp_valid first high in T+DIV_LAT+2.
REQ-025 RESP: resp_valid[grant] SHALL stay high with resp_z stable until resp_ready[grant] is sampled high; on that edge the block SHALL set last_grant to grant and go to IDLE.
REQ-026 resp_ready bits of non-granted requesters SHALL be ignored.
REQ-027 No new request SHALL be accepted in ISSUE, WAIT or RESP, whatever req_valid does.
REQ-028 A requester that drops req_valid before its req_ready strobe SHALL NOT be served.
REQ-029 A stalled resp_ready SHALL hold the FSM in RESP indefinitely with no timeout.
REQ-030 The block SHALL pass operands and results unmodified and SHALL NOT decode NaN, Inf or zero.

Reset
REQ-031 While reset is low at a clock edge, the block SHALL force IDLE; clear req_ready, resp_valid, div_start and busy; set resp_z, div_a, div_b and the counter to 0 and grant_id to 0; set last_grant to NREQ-1 so requester 0 has first priority.
REQ-032 Reset during ISSUE, WAIT or RESP SHALL abandon the operation; the later div_z value SHALL NOT be captured or reported.
REQ-033 The first request after reset release SHALL be accepted no earlier than the first edge with reset high.

Verification
REQ-034 DIV_LAT=16; requester 0 sends a=0x40C00000, b=0x40000000, and the divider model returns 0x40400000 -> req_ready[0] in T, div_start in T+1, resp_valid[0] in T+18 with resp_z=0x40400000.
REQ-035 All four req_valid are held high with resp_ready tied high -> service order is 0,1,2,3,0; each req_ready is one cycle; busy drops for one IDLE cycle between operations.
REQ-036 resp_ready[2] is held low for 10 cycles while requester 2 is in RESP -> resp_valid[2] and resp_z are stable for 10 cycles; req_valid[1] is not accepted until after completion.
REQ-037 Reset is asserted in the 5th WAIT cycle -> next cycle all outputs are 0 and busy is 0; with requesters 1 and 3 pending, the next grant goes to 1.
REQ-038 req_valid[3] is pulsed for one cycle during WAIT -> req_ready[3] is never asserted and no response is issued for requester 3.
REQ-039 In RESP, resp_ready[0] is driven high while requester 1 is granted -> no completion occurs and the FSM stays in RESP until resp_ready[1] is high.
